bringup_csr: RTL

- Avalon-MM slave CSR block on the bring-up system's JTAG-to-Avalon master bus, downstream of the master and beside the 4 KB on-chip RAM.
- Gives System Console a fixed ID, a scratch register, LED control, a 64-bit cycle counter with atomic snapshot, a write-transaction counter and sticky error flags.
- Confirms JTAG bus read/write integrity and clock liveness during Milestone 1.2 bring-up.

---
 rtl/bringup_csr_pkg.sv | 33 +++
 rtl/bringup_csr_cnt64.sv | 45 ++++
 rtl/bringup_csr.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bringup_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bringup_csr_pkg
// Brief   : Register index map, ID default and bit positions for bringup_csr.
// Revision: 1.0 - initial release
// ============================================================================
package bringup_csr_pkg;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA10B_0102;
    localparam logic [31:0] UNMAPPED_DATA    = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ADDR_ID      = 3'd0,
        ADDR_SCRATCH = 3'd1,
        ADDR_LED     = 3'd2,
        ADDR_CYC_LO  = 3'd3,
        ADDR_CYC_HI  = 3'd4,
        ADDR_CTRL    = 3'd5,
        ADDR_WRCNT   = 3'd6,
        ADDR_ERR     = 3'd7
    } reg_idx_e;

    localparam int CTRL_CLR_BIT     = 0;
    localparam int CTRL_EN_BIT      = 1;
    localparam int ERR_UNMAPPED_BIT = 0;
    localparam int ERR_RDWR_BIT     = 1;

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bringup_csr_cnt64.sv
`default_nettype none
// ============================================================================
// Module  : bringup_csr_cnt64
// Brief   : 64-bit free-running cycle counter with clear and HI-word snapshot.
// Revision: 1.0 - initial release
// ============================================================================
module bringup_csr_cnt64 (
    input  logic        clk_50,
    input  logic        sys_reset_n,
    input  logic        en,
    input  logic        clr,
    input  logic        snap,
    output logic [31:0] cnt_lo,
    output logic [31:0] cnt_hi_shadow
);

    logic [63:0] r_cnt;
    logic [31:0] r_hi_shadow;

    always_ff @(posedge clk_50 or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 64'd1;
        end
    end

    // Snapshot takes the HI word present on the same edge the LO word is read.
    always_ff @(posedge clk_50 or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_hi_shadow <= '0;
        end else if (clr) begin
            r_hi_shadow <= '0;
        end else if (snap) begin
            r_hi_shadow <= r_cnt[63:32];
        end
    end

    assign cnt_lo        = r_cnt[31:0];
    assign cnt_hi_shadow = r_hi_shadow;

endmodule
`default_nettype wire

// File: rtl/bringup_csr.sv
`default_nettype none
// ============================================================================
// Module  : bringup_csr
// Brief   : Avalon-MM bring-up CSR block (ID, scratch, LEDs, cycle counter,
//           write counter, sticky errors). BRINGUP_CSR_BYTEEN_EN enables
//           byte-lane writes to SCRATCH/LED/CTRL.
// Revision: 1.0 - initial release
// ============================================================================
module bringup_csr
    import bringup_csr_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT,
    parameter int          ADDR_W   = 4,
    parameter int          WRCNT_W  = 16
) (
    input  logic              clk_50,
    input  logic              sys_reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic              avs_waitrequest,
    output logic [1:0]        led_ctrl,
    output logic              cnt_running
);

    logic               r_waitreq;
    logic [31:0]        r_scratch;
    logic [1:0]         r_led;
    logic               r_en;
    logic [WRCNT_W-1:0] r_wrcnt;
    logic [1:0]         r_err;
    logic [31:0]        r_rdata;
    logic               r_rvalid;

    logic               w_acc_wr;
    logic               w_acc_rd;
    logic               w_acc_rdwr;
    logic               w_mapped;
    reg_idx_e           w_idx;
    logic               w_wr_scratch;
    logic               w_wr_led;
    logic               w_wr_ctrl;
    logic               w_wr_err;
    logic               w_clr;
    logic               w_snap;
    logic [31:0]        w_wmask;
    logic [1:0]         w_err_set;
    logic [1:0]         w_err_clr;
    logic [31:0]        w_rdata;
    logic [31:0]        w_cnt_lo;
    logic [31:0]        w_cnt_hi;

    // Single stall cycle out of reset, never again.
    always_ff @(posedge clk_50 or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_waitreq <= 1'b1;
        end else begin
            r_waitreq <= 1'b0;
        end
    end

    assign w_acc_wr   = avs_write & ~r_waitreq;
    assign w_acc_rd   = avs_read & ~avs_write & ~r_waitreq;
    assign w_acc_rdwr = avs_read & avs_write & ~r_waitreq;
    assign w_mapped   = (avs_address[ADDR_W-1:3] == '0);
    assign w_idx      = reg_idx_e'(avs_address[2:0]);

    assign w_wr_scratch = w_acc_wr & w_mapped & (w_idx == ADDR_SCRATCH);
    assign w_wr_led     = w_acc_wr & w_mapped & (w_idx == ADDR_LED);
    assign w_wr_ctrl    = w_acc_wr & w_mapped & (w_idx == ADDR_CTRL);
    assign w_wr_err     = w_acc_wr & w_mapped & (w_idx == ADDR_ERR);
    assign w_snap       = w_acc_rd & w_mapped & (w_idx == ADDR_CYC_LO);

`ifdef BRINGUP_CSR_BYTEEN_EN
    assign w_wmask = byte_mask(avs_byteenable);
`else
    logic w_unused_be;
    assign w_unused_be = &{1'b0, avs_byteenable[3:1]};
    assign w_wmask     = '1;
`endif

    assign w_clr = w_wr_ctrl & avs_writedata[CTRL_CLR_BIT] & w_wmask[CTRL_CLR_BIT];

    always_ff @(posedge clk_50 or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_scratch <= '0;
            r_led     <= '0;
            r_en      <= 1'b1;
        end else begin
            if (w_wr_scratch) begin
                r_scratch <= (r_scratch & ~w_wmask) | (avs_writedata & w_wmask);
            end
            if (w_wr_led) begin
                r_led <= (r_led & ~w_wmask[1:0]) | (avs_writedata[1:0] & w_wmask[1:0]);
            end
            if (w_wr_ctrl && w_wmask[CTRL_EN_BIT]) begin
                r_en <= avs_writedata[CTRL_EN_BIT];
            end
        end
    end

    always_ff @(posedge clk_50 or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_wrcnt <= '0;
        end else if (w_acc_wr && (r_wrcnt != '1)) begin
            r_wrcnt <= r_wrcnt + 1'b1;
        end
    end

    // ERR clears always respect byte lane 0; a coincident set wins over clear.
    always_comb begin
        w_err_set                   = '0;
        w_err_set[ERR_UNMAPPED_BIT] = (avs_read | avs_write) & ~r_waitreq & ~w_mapped;
        w_err_set[ERR_RDWR_BIT]     = w_acc_rdwr;
        w_err_clr                   = w_wr_err ? (avs_writedata[1:0] & {2{avs_byteenable[0]}}) : 2'b00;
    end

    always_ff @(posedge clk_50 or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_err <= '0;
        end else begin
            r_err <= (r_err & ~w_err_clr) | w_err_set;
        end
    end

    bringup_csr_cnt64 u_cnt (
        .clk_50        (clk_50),
        .sys_reset_n   (sys_reset_n),
        .en            (r_en),
        .clr           (w_clr),
        .snap          (w_snap),
        .cnt_lo        (w_cnt_lo),
        .cnt_hi_shadow (w_cnt_hi)
    );

    always_comb begin
        w_rdata = UNMAPPED_DATA;
        if (w_mapped) begin
            case (w_idx)
                ADDR_ID:      w_rdata = ID_VALUE;
                ADDR_SCRATCH: w_rdata = r_scratch;
                ADDR_LED:     w_rdata = {30'd0, r_led};
                ADDR_CYC_LO:  w_rdata = w_cnt_lo;
                ADDR_CYC_HI:  w_rdata = w_cnt_hi;
                ADDR_CTRL:    w_rdata = {30'd0, r_en, 1'b0};
                ADDR_WRCNT:   w_rdata = 32'(r_wrcnt);
                ADDR_ERR:     w_rdata = {30'd0, r_err};
                default:      w_rdata = UNMAPPED_DATA;
            endcase
        end
    end

    always_ff @(posedge clk_50 or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_acc_rd;
            if (w_acc_rd) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign avs_readdata      = r_rdata;
    assign avs_readdatavalid = r_rvalid;
    assign avs_waitrequest   = r_waitreq;
    assign led_ctrl          = r_led;
    assign cnt_running       = r_en;

endmodule
`default_nettype wire
